// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-write store buffer with in-order bus drain and load hazard check
// Optional load forwarding from pending stores when STORE_BUF_FWD_EN is defined.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             st_valid,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [3:0]       st_byte_en,
    output logic             st_stall,
    input  logic             ld_valid,
    input  logic [31:0]      ld_addr,
    output logic             ld_stall,
    output logic             ld_fwd_hit,
    output logic [31:0]      ld_fwd_data,
    output logic             bus_valid,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_data,
    output logic [3:0]       bus_byte_en,
    input  logic             bus_ready,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [29:0]      ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [3:0]       ent_be   [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count_q;

    logic full;
    logic st_real;
    logic push;
    logic pop;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign st_real   = st_valid && (st_byte_en != 4'b0000);
    // A full buffer refuses the store even if the head retires this cycle.
    assign push      = st_real && !full;
    assign st_stall  = st_real && full;
    assign bus_valid = !empty;
    assign pop       = bus_valid && bus_ready;

    assign bus_addr    = {ent_addr[head], 2'b00};
    assign bus_data    = ent_data[head];
    assign bus_byte_en = ent_be[head];
    assign count       = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            if (push)
                tail <= tail + PTR_W'(1);
            if (pop)
                head <= head + PTR_W'(1);
            if (push && !pop)
                count_q <= count_q + CNT_W'(1);
            else if (!push && pop)
                count_q <= count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= st_addr[31:2];
            ent_data[tail] <= st_data;
            ent_be[tail]   <= st_byte_en;
        end
    end

    // Walk occupied entries oldest to youngest so younger lanes win the merge.
    logic             match;
    logic [31:0]      merged_data;
    logic [3:0]       merged_be;
    logic [PTR_W-1:0] idx;

    always_comb begin
        match       = 1'b0;
        merged_data = '0;
        merged_be   = '0;
        idx         = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (ent_addr[idx] == ld_addr[31:2])) begin
                match = 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (ent_be[idx][b]) begin
                        merged_data[8*b +: 8] = ent_data[idx][8*b +: 8];
                        merged_be[b]          = 1'b1;
                    end
                end
            end
        end
    end

`ifdef STORE_BUF_FWD_EN
    assign ld_fwd_hit  = ld_valid && match && (merged_be == 4'b1111);
    assign ld_fwd_data = ld_fwd_hit ? merged_data : '0;
    assign ld_stall    = ld_valid && match && !ld_fwd_hit;
`else
    logic unused_merge;
    assign unused_merge = ^{merged_data, merged_be};
    assign ld_fwd_hit   = 1'b0;
    assign ld_fwd_data  = '0;
    assign ld_stall     = ld_valid && match;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - randomized store_buffer bench against a queue-based reference model
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [31:0]      st_data;
    logic [3:0]       st_byte_en;
    logic             st_stall;
    logic             ld_valid;
    logic [31:0]      ld_addr;
    logic             ld_stall;
    logic             ld_fwd_hit;
    logic [31:0]      ld_fwd_data;
    logic             bus_valid;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_data;
    logic [3:0]       bus_byte_en;
    logic             bus_ready;
    logic             empty;
    logic [CNT_W-1:0] count;

    store_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
        .st_byte_en(st_byte_en), .st_stall(st_stall),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_stall(ld_stall),
        .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_byte_en(bus_byte_en), .bus_ready(bus_ready),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [29:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;

    ent_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   exp_push;
    bit   exp_pop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic check_outputs();
        bit          full;
        bit          m;
        logic [31:0] md;
        logic [3:0]  mb;
        bit          hit;
        full = (q.size() == DEPTH);
        chk("st_stall", st_stall, st_valid && (st_byte_en != 0) && full);
        chk("count", 32'(count), q.size());
        chk("empty", empty, q.size() == 0);
        chk("bus_valid", bus_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("bus_addr", bus_addr, {q[0].a, 2'b00});
            chk("bus_data", bus_data, q[0].d);
            chk("bus_byte_en", bus_byte_en, q[0].be);
        end
        m = 0; md = '0; mb = '0;
        foreach (q[i]) begin
            if (q[i].a == ld_addr[31:2]) begin
                m = 1;
                for (int b = 0; b < 4; b++)
                    if (q[i].be[b]) begin
                        md[8*b +: 8] = q[i].d[8*b +: 8];
                        mb[b] = 1'b1;
                    end
            end
        end
`ifdef STORE_BUF_FWD_EN
        hit = ld_valid && m && (mb == 4'hF);
        chk("ld_fwd_hit", ld_fwd_hit, hit);
        if (hit) chk("ld_fwd_data", ld_fwd_data, md);
        chk("ld_stall", ld_stall, ld_valid && m && !hit);
`else
        hit = 0;
        chk("ld_fwd_hit", ld_fwd_hit, hit);
        chk("ld_fwd_data", ld_fwd_data, 32'h0);
        chk("ld_stall", ld_stall, ld_valid && m);
`endif
        exp_push = st_valid && (st_byte_en != 0) && !full;
        exp_pop  = (q.size() != 0) && bus_ready;
    endtask

    // Inputs are set after a falling edge; check, clock, update model.
    task automatic cycle();
        ent_t e;
        #1;
        check_outputs();
        @(posedge clk);
        if (reset) begin
            q.delete();
        end else begin
            if (exp_pop) void'(q.pop_front());
            if (exp_push) begin
                e.a = st_addr[31:2]; e.d = st_data; e.be = st_byte_en;
                q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        st_valid = 0; ld_valid = 0; reset = 0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        st_valid = 1; st_addr = a; st_data = d; st_byte_en = be; ld_valid = 0;
    endtask

    task automatic load(input logic [31:0] a);
        ld_valid = 1; ld_addr = a; st_valid = 0;
    endtask

    int ready_bias;

    initial begin
        reset = 1; st_valid = 0; st_addr = 0; st_data = 0; st_byte_en = 0;
        ld_valid = 0; ld_addr = 0; bus_ready = 0;
        @(posedge clk);
        @(negedge clk);
        idle();
        cycle();                                    // reset state

        bus_ready = 1;                              // single word store and retire
        store(32'h100, 32'h11223344, 4'hF); cycle();
        idle(); cycle(); cycle();

        bus_ready = 0;                              // fill, stall, release one slot
        for (int i = 0; i < DEPTH; i++) begin
            store(32'h300 + 32'(4*i), $urandom, 4'hF); cycle();
        end
        store(32'h3F0, 32'hDEADBEEF, 4'hF); cycle();
        bus_ready = 1; cycle();
        bus_ready = 0; cycle();
        idle(); bus_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();

        store(32'h104, 32'h55555555, 4'h0); cycle(); // zero enables dropped
        idle(); cycle();

        bus_ready = 0;                              // partial then full coverage
        store(32'h203, 32'hAA000000, 4'h8); cycle();
        load(32'h200); cycle();
        store(32'h200, 32'h12345678, 4'hF); cycle();
        store(32'h203, 32'hAA000000, 4'h8); cycle();
        load(32'h200); cycle();
`ifdef STORE_BUF_FWD_EN
        chk("fwd_word", ld_fwd_data, 32'hAA345678);
`endif
        bus_ready = 1;
        for (int i = 0; i < 4; i++) cycle();

        idle(); bus_ready = 0;                      // reset discards pending
        for (int i = 0; i < 3; i++) begin
            store(32'h400 + 32'(4*i), $urandom, 4'hF); cycle();
        end
        idle(); reset = 1; cycle();
        reset = 0; bus_ready = 1; cycle(); cycle();

        ready_bias = 5;
        for (int n = 0; n < 3000; n++) begin
            int op;
            if (n % 64 == 0) ready_bias = $urandom_range(0, 10);
            idle();
            reset     = ($urandom_range(0, 299) == 0);
            bus_ready = ($urandom_range(0, 9) < ready_bias);
            op = $urandom_range(0, 9);
            if (op < 5)
                store(32'h200 + 32'(4*$urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
                      $urandom, 4'($urandom_range(0, 15)));
            else if (op < 8)
                load(32'h200 + 32'(4*$urandom_range(0, 5)) + 32'($urandom_range(0, 3)));
            cycle();
        end

        idle(); bus_ready = 1;
        for (int i = 0; i < DEPTH + 1; i++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
